// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU core: fetch/decode/exec sequencer with req/ack memory ports
// driving a single combinational Hack ALU.
module hack_cpu_mc (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [14:0] pc,
  output logic        retire
);
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 15;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MREAD  = 3'd2,
    EXEC   = 3'd3,
    MWRITE = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] a_q, a_d, d_q, d_d, m_q, m_d, ir_q, ir_d;
  logic [DW-1:0] wdata_d;
  logic [AW-1:0] pc_d, addr_d;
  logic          imem_req_d, dmem_req_d, dmem_we_d;

  logic [DW-1:0] alu_y, alu_out;
  logic          alu_zr, alu_ng, jump;

  // ALU datapath: x is always D, y selects between M and A by the a-bit
  assign alu_y = ir_q[12] ? m_q : a_q;

  ALU u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (ir_q[11]),
    .nx  (ir_q[10]),
    .zy  (ir_q[9]),
    .ny  (ir_q[8]),
    .f   (ir_q[7]),
    .no  (ir_q[6]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump      = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);
  assign imem_addr = pc;

  // Next-state and next-register values; retire decodes the final cycle of each instruction
  always_comb begin
    state_d    = state;
    a_d        = a_q;
    d_d        = d_q;
    m_d        = m_q;
    ir_d       = ir_q;
    pc_d       = pc;
    addr_d     = dmem_addr;
    wdata_d    = dmem_wdata;
    imem_req_d = imem_req;
    dmem_req_d = dmem_req;
    dmem_we_d  = dmem_we;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        // First cycle after reset has no request outstanding yet; raise it here
        if (!imem_req) begin
          imem_req_d = 1'b1;
        end else if (imem_ack) begin
          ir_d       = imem_data;
          imem_req_d = 1'b0;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        if (!ir_q[15]) begin
          a_d        = ir_q;
          pc_d       = pc + AW'(1);
          retire     = 1'b1;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end else begin
          addr_d = a_q[AW-1:0];
          if (ir_q[12]) begin
            dmem_req_d = 1'b1;
            dmem_we_d  = 1'b0;
            state_d    = MREAD;
          end else begin
            state_d = EXEC;
          end
        end
      end
      MREAD: begin
        if (dmem_req && dmem_ack) begin
          m_d        = dmem_rdata;
          dmem_req_d = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (ir_q[5]) a_d = alu_out;
        if (ir_q[4]) d_d = alu_out;
        pc_d = jump ? a_q[AW-1:0] : pc + AW'(1);
        if (ir_q[3]) begin
          wdata_d    = alu_out;
          dmem_req_d = 1'b1;
          dmem_we_d  = 1'b1;
          state_d    = MWRITE;
        end else begin
          retire     = 1'b1;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end
      end
      MWRITE: begin
        if (dmem_req && dmem_ack) begin
          retire     = 1'b1;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          imem_req_d = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FETCH;
      a_q        <= '0;
      d_q        <= '0;
      m_q        <= '0;
      ir_q       <= '0;
      pc         <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
    end else begin
      state      <= state_d;
      a_q        <= a_d;
      d_q        <= d_d;
      m_q        <= m_d;
      ir_q       <= ir_d;
      pc         <= pc_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      imem_req   <= imem_req_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
    end
  end

endmodule

// Combinational Hack ALU: optional zero/negate of each operand, add or and, optional output negate.
module ALU (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x1, x2, y1, y2, sum, res;

  assign x1  = zx ? 16'h0000 : x;
  assign x2  = nx ? ~x1 : x1;
  assign y1  = zy ? 16'h0000 : y;
  assign y2  = ny ? ~y1 : y1;
  assign sum = x2 + y2;
  assign res = f ? sum : (x2 & y2);
  assign out = no ? ~res : res;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];

endmodule
